outlier_accum: RTL and testbench

// Downstream of the outlier segment: consumes the NUM_LR fp16 outlier products

---
 rtl/outlier_accum.sv | 220 ++++++++++++++++++++++
 tb/tb_outlier_accum.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/outlier_accum.sv
// Serial fp16 accumulator for the outlier path: sums the masked-in lanes of each beat,
// one lane per cycle, across a multi-beat dot-product and offers the sum on valid/ready.
module outlier_accum #(
   parameter int unsigned NUM_LR    = 4,
   parameter int unsigned sig_width = 10,
   parameter int unsigned exp_width = 5,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic [NUM_LR-1:0][sig_width+exp_width:0] in_prod,
   input  logic [NUM_LR-1:0]                        in_mask,
   input  logic                                     in_last,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [sig_width+exp_width:0]             out_sum,
   output logic [CNT_W-1:0]                         out_cnt,
   output logic [7:0]                               out_status
);
   localparam int unsigned FP_W   = sig_width + exp_width + 1;
   localparam int unsigned MAN_W  = sig_width + 1;
   localparam int unsigned EMAX   = (1 << exp_width) - 1;
   localparam int unsigned FIX_W  = MAN_W + EMAX - 1;
   localparam int unsigned LANE_W = (NUM_LR > 1) ? $clog2(NUM_LR) : 1;

   typedef logic [FIX_W-1:0] fix_t;
   typedef enum logic [1:0] {IDLE, ADD, OUT} state_e;

   // Finite operand as an exact integer multiple of the smallest subnormal.
   function automatic fix_t to_fix(input logic [FP_W-1:0] x);
      logic [exp_width-1:0] e;
      logic [MAN_W-1:0]     m;
      e = x[FP_W-2:sig_width];
      m = {(e != '0), x[sig_width-1:0]};
      return FIX_W'(m) << ((e == '0) ? exp_width'(0) : e - exp_width'(1));
   endfunction

   // fp add, round-to-nearest-even; returns {status, result}.
   function automatic logic [FP_W+7:0] fp_add(input logic [FP_W-1:0] a,
                                              input logic [FP_W-1:0] b);
      logic                 sa, sb, sr, a_spec, b_spec, a_nan, b_nan;
      logic                 guard, sticky;
      logic [exp_width-1:0] ea, eb;
      fix_t                 fa, fb, mag;
      logic [MAN_W:0]       m;
      logic [FP_W-1:0]      res;
      logic [7:0]           sts;
      int unsigned          p, sh, e_out;
      sa     = a[FP_W-1];
      sb     = b[FP_W-1];
      ea     = a[FP_W-2:sig_width];
      eb     = b[FP_W-2:sig_width];
      a_spec = &ea;
      b_spec = &eb;
      a_nan  = a_spec & (|a[sig_width-1:0]);
      b_nan  = b_spec & (|b[sig_width-1:0]);
      fa     = to_fix(a);
      fb     = to_fix(b);
      sr     = 1'b0;
      mag    = '0;
      m      = '0;
      res    = '0;
      sts    = '0;
      p      = 0;
      sh     = 0;
      e_out  = 0;
      guard  = 1'b0;
      sticky = 1'b0;
      if (a_nan | b_nan | (a_spec & b_spec & (sa != sb))) begin
         res    = {1'b0, {exp_width{1'b1}}, 1'b1, {(sig_width-1){1'b0}}};
         sts[2] = 1'b1;
      end else if (a_spec | b_spec) begin
         res    = {(a_spec ? sa : sb), {exp_width{1'b1}}, {sig_width{1'b0}}};
         sts[1] = 1'b1;
      end else begin
         if (sa == sb) begin
            mag = fa + fb;
            sr  = sa;
         end else if (fa >= fb) begin
            mag = fa - fb;
            sr  = (fa == fb) ? 1'b0 : sa;
         end else begin
            mag = fb - fa;
            sr  = sb;
         end
         for (int i = 0; i < FIX_W; i++) begin
            if (|(mag >> i)) p = i;
         end
         if (p < MAN_W) begin
            // Fits in the significand exactly: subnormal or lowest binade.
            res    = {sr, exp_width'(mag[sig_width]), mag[sig_width-1:0]};
            sts[0] = (mag == '0);
            sts[3] = (mag != '0) & ~mag[sig_width];
         end else begin
            sh     = p - sig_width;
            m      = (MAN_W+1)'(mag >> sh);
            guard  = |(mag & (FIX_W'(1) << (sh - 1)));
            sticky = |(mag & ((FIX_W'(1) << (sh - 1)) - FIX_W'(1)));
            m      = m + (MAN_W+1)'(guard & (sticky | m[0]));
            e_out  = p - sig_width + 1;
            if (m[MAN_W]) begin
               m     = m >> 1;
               e_out = e_out + 1;
            end
            sts[5] = guard | sticky;
            if (e_out >= EMAX) begin
               res    = {sr, {exp_width{1'b1}}, {sig_width{1'b0}}};
               sts[1] = 1'b1;
               sts[4] = 1'b1;
               sts[5] = 1'b1;
            end else begin
               res = {sr, exp_width'(e_out), m[sig_width-1:0]};
            end
         end
      end
      return {sts, res};
   endfunction

   state_e                         state_q, state_d;
   logic [FP_W-1:0]                acc_q, acc_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [7:0]                     sts_q, sts_d;
   logic [LANE_W-1:0]              lane_q, lane_d;
   logic [NUM_LR-1:0][FP_W-1:0]    prod_q, prod_d;
   logic [NUM_LR-1:0]              mask_q, mask_d;
   logic                           last_q, last_d;
   logic                           in_ready_q, in_ready_d;
   logic                           out_valid_q, out_valid_d;
   logic [FP_W-1:0]                out_sum_q, out_sum_d;
   logic [CNT_W-1:0]               out_cnt_q, out_cnt_d;
   logic [7:0]                     out_status_q, out_status_d;
   logic [FP_W+7:0]                add_c;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sts_d   = sts_q;
      lane_d  = lane_q;
      prod_d  = prod_q;
      mask_d  = mask_q;
      last_d  = last_q;
      add_c   = fp_add(acc_q, prod_q[lane_q]);
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               prod_d  = in_prod;
               mask_d  = in_mask;
               last_d  = in_last;
               lane_d  = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            // Masked-off lanes still take a cycle so latency is fixed.
            if (mask_q[lane_q]) begin
               acc_d = add_c[FP_W-1:0];
               cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
               sts_d = sts_q | add_c[FP_W+7:FP_W];
            end
            lane_d = lane_q + LANE_W'(1);
            if (lane_q == LANE_W'(NUM_LR - 1)) state_d = last_q ? OUT : IDLE;
         end
         OUT: begin
            if (out_ready) begin
               acc_d   = '0;
               cnt_d   = '0;
               sts_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d   = (state_d == IDLE);
      out_valid_d  = (state_d == OUT);
      out_sum_d    = (state_d == OUT) ? acc_d : '0;
      out_cnt_d    = (state_d == OUT) ? cnt_d : '0;
      out_status_d = (state_d == OUT) ? sts_d : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         cnt_q        <= '0;
         sts_q        <= '0;
         lane_q       <= '0;
         prod_q       <= '0;
         mask_q       <= '0;
         last_q       <= 1'b0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         out_sum_q    <= '0;
         out_cnt_q    <= '0;
         out_status_q <= '0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         sts_q        <= sts_d;
         lane_q       <= lane_d;
         prod_q       <= prod_d;
         mask_q       <= mask_d;
         last_q       <= last_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         out_sum_q    <= out_sum_d;
         out_cnt_q    <= out_cnt_d;
         out_status_q <= out_status_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_sum    = out_sum_q;
   assign out_cnt    = out_cnt_q;
   assign out_status = out_status_q;
endmodule

// File: tb/tb_outlier_accum.sv
// Bench for outlier_accum: directed cases plus random dot-products checked against a
// real-arithmetic reference that rounds the exact sum to fp16 (nearest-even).
module tb_outlier_accum;
   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [3:0][15:0] in_prod;
   logic [3:0]       in_mask;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_sum;
   logic [15:0]      out_cnt;
   logic [7:0]       out_status;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_acc;
   logic [15:0] m_cnt;
   logic [7:0]  m_sts;

   outlier_accum #(.NUM_LR(4), .sig_width(10), .exp_width(5), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_prod(in_prod), .in_mask(in_mask), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_cnt(out_cnt), .out_status(out_status)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic real pow2(input int k);
      real r = 1.0;
      if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
      else        for (int i = 0; i < -k; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real fp_to_real(input logic [15:0] x);
      int  e = int'(x[14:10]);
      real v;
      if (e == 0) v = real'(int'(x[9:0])) * pow2(-24);
      else        v = real'(1024 + int'(x[9:0])) * pow2(e - 25);
      return x[15] ? -v : v;
   endfunction

   task automatic real_to_fp(input real x, input logic neg_zero,
                             output logic [15:0] r, output logic [7:0] flags);
      real  ax, m, fr;
      int   e, mi;
      logic s;
      s     = (x < 0.0);
      ax    = s ? -x : x;
      flags = 8'h00;
      if (ax == 0.0) begin
         r = neg_zero ? 16'h8000 : 16'h0000;
      end else if (ax < pow2(-14)) begin
         r = {s, 5'd0, 10'($rtoi(ax * pow2(24)))};
      end else begin
         e = 1;
         while (e < 40 && ax >= pow2(e - 14)) e++;
         m  = ax * pow2(25 - e);
         mi = $rtoi(m);
         fr = m - real'(mi);
         if (fr != 0.0) flags[5] = 1'b1;
         if (fr > 0.5 || (fr == 0.5 && (mi % 2) == 1)) mi++;
         if (mi == 2048) begin
            mi = 1024;
            e++;
         end
         if (e >= 31) begin
            r     = {s, 5'h1F, 10'h000};
            flags = flags | 8'h12;
         end else begin
            r = {s, 5'(e), 10'(mi - 1024)};
         end
      end
   endtask

   task automatic model_add(input logic [15:0] p);
      logic [15:0] r;
      logic [7:0]  f;
      real_to_fp(fp_to_real(m_acc) + fp_to_real(p), (m_acc == 16'h8000) && (p == 16'h8000), r, f);
      m_acc = r;
      m_sts = m_sts | f;
      if (m_cnt != 16'hFFFF) m_cnt++;
   endtask

   task automatic send_beat(input logic [3:0][15:0] p, input logic [3:0] mk, input logic lst);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("wait_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_prod  = p;
      in_mask  = mk;
      in_last  = lst;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic collect(input string tag, input logic [15:0] e_sum, input logic [15:0] e_cnt,
                          input logic [7:0] e_sts, input logic [7:0] sts_mask, input int hold);
      int n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
      repeat (hold) @(negedge clk);
      check_eq({tag, "_sum"}, 32'(out_sum), 32'(e_sum));
      check_eq({tag, "_cnt"}, 32'(out_cnt), 32'(e_cnt));
      check_eq({tag, "_sts"}, 32'(out_status & sts_mask), 32'(e_sts & sts_mask));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq({tag, "_drop"}, 32'(out_valid), 32'd0);
   endtask

   function automatic logic [15:0] rand_fp();
      return {1'($urandom), 5'($urandom_range(0, 20)), 10'($urandom)};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, n_low, nb, hold;
      logic [3:0][15:0] p;
      logic [3:0]       mk;
      rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_mask = '0; in_last = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_sum", 32'(out_sum), 32'd0);
      check_eq("rst_out_cnt", 32'(out_cnt), 32'd0);
      check_eq("rst_out_sts", 32'(out_status), 32'd0);

      // 1: four lanes, latency and ready-low window
      out_ready = 1'b1;
      send_beat({16'h4400, 16'h4200, 16'h4000, 16'h3C00}, 4'b1111, 1'b1);
      first = 0;
      n_low = 0;
      for (int c = 1; c <= 12; c++) begin
         if (!in_ready) n_low++;
         if (out_valid && first == 0) begin
            first = c;
            check_eq("t1_sum", 32'(out_sum), 32'h4900);
            check_eq("t1_cnt", 32'(out_cnt), 32'd4);
         end
         @(negedge clk);
      end
      check_eq("t1_latency", 32'(first), 32'd5);
      check_eq("t1_ready_low", 32'(n_low), 32'd5);
      out_ready = 1'b0;

      // 2: two beats, only one output
      send_beat({16'h0000, 16'h0000, 16'h4000, 16'h3C00}, 4'b0011, 1'b0);
      n_low = 0;
      for (int c = 0; c < 8; c++) begin
         if (out_valid) n_low++;
         @(negedge clk);
      end
      check_eq("t2_no_early_valid", 32'(n_low), 32'd0);
      send_beat({16'h0000, 16'h0000, 16'h0000, 16'h4200}, 4'b0001, 1'b1);
      collect("t2", 16'h4600, 16'd3, 8'h00, 8'h00, 0);

      // 3: backpressure holds output stable
      send_beat({16'h0000, 16'h0000, 16'h4000, 16'h3C00}, 4'b0011, 1'b1);
      first = 0;
      while (!out_valid && first < 100) begin
         @(negedge clk);
         first++;
      end
      n_low = 0;
      for (int c = 0; c < 10; c++) begin
         if (!out_valid || out_sum !== 16'h4200 || out_cnt !== 16'd2 || in_ready) n_low++;
         @(negedge clk);
      end
      check_eq("t3_stable_cycles_bad", 32'(n_low), 32'd0);
      check_eq("t3_sum", 32'(out_sum), 32'h4200);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq("t3_idle_ready", 32'(in_ready), 32'd1);
      send_beat({16'h0000, 16'h0000, 16'h0000, 16'h3C00}, 4'b0001, 1'b1);
      collect("t3b", 16'h3C00, 16'd1, 8'h00, 8'h00, 0);

      // 4: empty and cancelling dot-products
      send_beat({16'h4400, 16'h4200, 16'h4000, 16'h3C00}, 4'b0000, 1'b1);
      collect("t4a", 16'h0000, 16'd0, 8'h00, 8'hFF, 0);
      send_beat({16'h0000, 16'h0000, 16'hC000, 16'h4000}, 4'b0011, 1'b1);
      collect("t4b", 16'h0000, 16'd2, 8'h00, 8'h00, 0);

      // 5: overflow to infinity
      send_beat({16'h0000, 16'h0000, 16'h7BFF, 16'h7BFF}, 4'b0011, 1'b1);
      collect("t5", 16'h7C00, 16'd2, 8'h12, 8'h12, 0);

      // 6: reset during the second accumulate cycle
      send_beat({16'h4400, 16'h4200, 16'h4000, 16'h3C00}, 4'b1111, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("t6_out_valid", 32'(out_valid), 32'd0);
      check_eq("t6_in_ready", 32'(in_ready), 32'd1);
      check_eq("t6_out_sum", 32'(out_sum), 32'd0);
      send_beat({16'h0000, 16'h0000, 16'h0000, 16'h3800}, 4'b0001, 1'b1);
      collect("t6", 16'h3800, 16'd1, 8'h00, 8'h00, 0);

      // random dot-products against the reference model
      for (int d = 0; d < 40; d++) begin
         m_acc = 16'h0000;
         m_cnt = 16'd0;
         m_sts = 8'h00;
         nb = $urandom_range(1, 3);
         for (int b = 0; b < nb; b++) begin
            for (int l = 0; l < 4; l++) p[l] = rand_fp();
            mk = 4'($urandom);
            for (int l = 0; l < 4; l++) if (mk[l]) model_add(p[l]);
            send_beat(p, mk, 1'(b == nb - 1));
         end
         hold = $urandom_range(0, 3);
         collect("rnd", m_acc, m_cnt, m_sts, 8'h32, hold);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
